// File: rtl/fir_io_pkg.sv
// Shared definitions for the FIR output path: width defaults, nibble count and
// the serializer state encoding.
package fir_io_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NIB_W_DEF  = 4;
    localparam int NIBS       = DATA_W_DEF / NIB_W_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    function automatic int nib_count(input int data_w, input int nib_w);
        return data_w / nib_w;
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Generic synchronous FIFO. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; the read word is presented combinationally at the head.
module fir_sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    output logic [W-1:0]  o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_out_serializer.sv
// Buffers FIR results and streams each word LSB-nibble-first with a frame strobe.
// Valid/ready: in_valid has no ready (the core cannot stall); out_hold freezes the stream.
module fir_out_serializer
    import fir_io_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NIB_W      = NIB_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_hold,
    output logic              out_valid,
    output logic              out_frame,
    output logic [NIB_W-1:0]  out_nibble,
    output logic [CNT_W-1:0]  drop_cnt,
    output ser_state_t        dbg_state
);

    localparam int N_NIBS = nib_count(DATA_W, NIB_W);
    localparam int IDX_W  = (N_NIBS > 1) ? $clog2(N_NIBS) : 1;
    localparam int FAW    = $clog2(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIBS - 1);

    ser_state_t        r_state;
    ser_state_t        w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_drop;

    logic [DATA_W-1:0] w_fifo_rdata;
    logic              w_full;
    logic              w_empty;
    logic [FAW:0]      w_count;
    logic              w_load;
    logic              w_accept;
    logic              w_drop;

    // A load can only happen on an idle block or on the last nibble of a frame.
    assign w_load = !w_empty && !out_hold &&
                    ((r_state == IDLE) || ((r_state == SEND) && (r_idx == LAST_IDX)));
    assign w_accept = (w_count < (FAW+1)'(FIFO_DEPTH)) || (w_full && w_load);
    assign w_drop   = in_valid && !w_accept;

    fir_sync_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid && w_accept),
        .i_wdata (in_data),
        .i_pop   (w_load),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (!out_hold && (r_idx == LAST_IDX) && !w_load) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid  = 1'b0;
        out_frame  = 1'b0;
        out_nibble = '0;
        if (r_state == SEND) begin
            out_valid  = 1'b1;
            out_frame  = (r_idx == '0);
            out_nibble = r_shift[NIB_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (w_load) begin
            r_shift <= w_fifo_rdata;
            r_idx   <= '0;
        end else if ((r_state == SEND) && !out_hold) begin
            r_shift <= r_shift >> NIB_W;
            r_idx   <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != '1)) begin
            r_drop <= r_drop + 1'b1;
        end
    end

    assign drop_cnt  = r_drop;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fir_out_serializer.sv
// Directed scoreboard bench for fir_out_serializer: single word, back-to-back,
// hold, overflow, reset mid-frame and drop-counter saturation.
module tb_fir_out_serializer;
    import fir_io_pkg::*;

    localparam int DW = 32;
    localparam int NW = 4;
    localparam int NN = DW / NW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_hold;
    logic          out_valid;
    logic          out_frame;
    logic [NW-1:0] out_nibble;
    logic [7:0]    drop_cnt;
    ser_state_t    dut_state;

    logic          sat_valid;
    logic [DW-1:0] sat_data;
    logic          sat_hold;
    logic          sat_out_valid;
    logic          sat_out_frame;
    logic [NW-1:0] sat_out_nibble;
    logic [1:0]    sat_drop_cnt;
    ser_state_t    sat_state;

    always #5 clk = ~clk;

    fir_out_serializer u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_hold   (out_hold),
        .out_valid  (out_valid),
        .out_frame  (out_frame),
        .out_nibble (out_nibble),
        .drop_cnt   (drop_cnt),
        .dbg_state  (dut_state)
    );

    fir_out_serializer #(.CNT_W(2)) u_sat (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (sat_valid),
        .in_data    (sat_data),
        .out_hold   (sat_hold),
        .out_valid  (sat_out_valid),
        .out_frame  (sat_out_frame),
        .out_nibble (sat_out_nibble),
        .drop_cnt   (sat_drop_cnt),
        .dbg_state  (sat_state)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [NW:0] exp_q[$];
    int          cyc = 0;
    int          base;
    int          first_v;
    int          last_v;
    int          valid_cnt;
    int          c_count;
    int          frame_cyc[$];
    logic        last_valid = 1'b0;
    logic        last_hold  = 1'b0;
    logic [NW-1:0] last_nib = '0;
    logic        snap_valid;
    logic        snap_frame;
    logic [NW-1:0] snap_nib;
    logic [7:0]  snap_drop;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] w);
        for (int i = 0; i < NN; i++) begin
            exp_q.push_back({(i == 0), w[i*NW +: NW]});
        end
    endtask

    task automatic reset_tracking();
        first_v   = -1;
        last_v    = -1;
        valid_cnt = 0;
        c_count   = 0;
        frame_cyc.delete();
    endtask

    task automatic observe();
        logic [NW:0] e;
        snap_valid = out_valid;
        snap_frame = out_frame;
        snap_nib   = out_nibble;
        snap_drop  = drop_cnt;
        if (out_valid) begin
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
            valid_cnt++;
            if (out_frame) frame_cyc.push_back(cyc);
            if (out_nibble == 4'hC) c_count++;
            if (last_valid && last_hold) begin
                check("hold_nibble", 32'(out_nibble), 32'(last_nib));
            end else if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("nibble", 32'(out_nibble), 32'(e[NW-1:0]));
                check("frame", 32'(out_frame), 32'(e[NW]));
            end
        end
        last_valid = out_valid;
        last_hold  = out_hold;
        last_nib   = out_nibble;
    endtask

    // One clock cycle: drive just after the rising edge, observe on the falling edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic h, input logic r);
        #1;
        in_valid = v;
        in_data  = d;
        out_hold = h;
        rst      = r;
        @(negedge clk);
        observe();
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        exp_q.delete();
        reset_tracking();
    endtask

    logic [DW-1:0] w;
    logic [DW-1:0] words[10];

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_hold = 1'b0;
        sat_valid = 1'b0; sat_data = '0; sat_hold = 1'b1;
        @(posedge clk);

        // Reset state
        do_reset();
        check("rst_valid", 32'(snap_valid), 32'd0);
        check("rst_frame", 32'(snap_frame), 32'd0);
        check("rst_nibble", 32'(snap_nib), 32'd0);
        check("rst_drop", 32'(snap_drop), 32'd0);
        check("rst_state", 32'(dut_state), 32'(IDLE));
        check("rst_sat_drop", 32'(sat_drop_cnt), 32'd0);

        // Single word
        do_reset();
        base = cyc;
        w = 32'h89ABCDEF;
        push_exp(w);
        step(1'b1, w, 1'b0, 1'b0);
        idle(12);
        check("single_first", 32'(first_v - base), 32'd2);
        check("single_last", 32'(last_v - base), 32'd9);
        check("single_len", 32'(valid_cnt), 32'd8);
        check("single_nframes", 32'(frame_cyc.size()), 32'd1);
        check("single_frame_cyc", 32'(frame_cyc[0] - base), 32'd2);
        check("single_drained", 32'(exp_q.size()), 32'd0);

        // Back-to-back
        do_reset();
        base = cyc;
        push_exp(32'h00000001);
        step(1'b1, 32'h00000001, 1'b0, 1'b0);
        push_exp(32'h76543210);
        step(1'b1, 32'h76543210, 1'b0, 1'b0);
        idle(20);
        check("b2b_first", 32'(first_v - base), 32'd2);
        check("b2b_last", 32'(last_v - base), 32'd17);
        check("b2b_len", 32'(valid_cnt), 32'd16);
        check("b2b_nframes", 32'(frame_cyc.size()), 32'd2);
        check("b2b_frame0", 32'(frame_cyc[0] - base), 32'd2);
        check("b2b_frame1", 32'(frame_cyc[1] - base), 32'd10);
        check("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Hold for three cycles on nibble index 3
        do_reset();
        base = cyc;
        w = 32'h89ABCDEF;
        push_exp(w);
        step(1'b1, w, 1'b0, 1'b0);
        idle(4);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        idle(10);
        check("hold_c_cycles", 32'(c_count), 32'd4);
        check("hold_first", 32'(first_v - base), 32'd2);
        check("hold_span", 32'(last_v - first_v + 1), 32'd11);
        check("hold_len", 32'(valid_cnt), 32'd11);
        check("hold_drained", 32'(exp_q.size()), 32'd0);

        // Overflow: w5..w8 dropped, w9 accepted alongside the pop
        do_reset();
        for (int i = 0; i < 10; i++) begin
            words[i] = $urandom();
            if (i <= 4 || i == 9) push_exp(words[i]);
            step(1'b1, words[i], 1'b0, 1'b0);
        end
        idle(60);
        check("ovf_drop", 32'(drop_cnt), 32'd4);
        check("ovf_len", 32'(valid_cnt), 32'd48);
        check("ovf_nframes", 32'(frame_cyc.size()), 32'd6);
        check("ovf_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame (drop_cnt still 4 from the overflow run)
        reset_tracking();
        words[0] = $urandom_range(32'h7FFFFFFF, 32'h10000000);
        words[1] = $urandom();
        words[2] = $urandom();
        push_exp(words[0]);
        step(1'b1, words[0], 1'b0, 1'b0);
        step(1'b1, words[1], 1'b0, 1'b0);
        step(1'b1, words[2], 1'b0, 1'b0);
        idle(4);
        step(1'b1, $urandom(), 1'b0, 1'b1);
        check("mid_rst_remaining", 32'(exp_q.size()), 32'd2);
        exp_q.delete();
        reset_tracking();
        idle(1);
        check("mid_rst_valid", 32'(snap_valid), 32'd0);
        check("mid_rst_frame", 32'(snap_frame), 32'd0);
        check("mid_rst_nibble", 32'(snap_nib), 32'd0);
        check("mid_rst_drop", 32'(snap_drop), 32'd0);
        idle(15);
        check("mid_rst_no_queued", 32'(valid_cnt), 32'd0);
        base = cyc;
        w = $urandom();
        push_exp(w);
        step(1'b1, w, 1'b0, 1'b0);
        idle(12);
        check("mid_rst_new_frame", 32'(frame_cyc.size() > 0 ? frame_cyc[0] - base : -1), 32'd2);
        check("mid_rst_new_len", 32'(valid_cnt), 32'd8);
        check("mid_rst_drained", 32'(exp_q.size()), 32'd0);

        // Drop counter saturation on the 2-bit instance held off
        sat_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sat_data = $urandom();
            idle(1);
        end
        sat_valid = 1'b0;
        idle(1);
        check("sat_drop", 32'(sat_drop_cnt), 32'd3);
        check("sat_no_output", 32'(sat_out_valid), 32'd0);
        idle(5);
        check("sat_drop_stays", 32'(sat_drop_cnt), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fir_out_serializer.md
# fir_out_serializer

Narrows the FIR core's 32-bit parallel result to a 4-bit nibble stream so the chip's output path needs 6 pads instead of 32, the same width as the 4-bit input path. It sits inside the chip wrapper between the `fir` core output and the output pads, buffers results in a small FIFO, and transmits each word LSB-nibble-first with a frame strobe. The FIR core cannot be stalled, so words arriving while the FIFO is full are dropped and counted.

## Interface

**Parameters**
- `DATA_W`, default 32: width of the FIR result word.
- `NIB_W`, default 4: width of the output nibble. `DATA_W` must be a multiple of `NIB_W`.
- `FIFO_DEPTH`, default 4: number of buffered words. Must be a power of 2 and at least 2.
- `CNT_W`, default 8: width of the drop counter.

**Ports**
- `clk`, input, 1: the single clock. Rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: the core presents a new result this cycle.
- `in_data`, input, `DATA_W`: the FIR result. Sampled only when `in_valid` is high.
- `out_hold`, input, 1: receiver backpressure from a pad. Must be synchronous to `clk`; the block does not synchronize it.
- `out_valid`, output, 1: `out_nibble` carries live data.
- `out_frame`, output, 1: high on the first nibble (nibble 0) of each word.
- `out_nibble`, output, `NIB_W`: the current nibble.
- `drop_cnt`, output, `CNT_W`: saturating count of dropped words.

## Operation

- **Reset.** All outputs are 0, the FIFO is empty, and the FSM is in IDLE.
- **FIFO write.** The word is written when `in_valid` is high and either count < `FIFO_DEPTH`, or count == `FIFO_DEPTH` and a pop occurs in the same cycle.
- **Drop.** Otherwise the word is discarded and `drop_cnt` increments. At the maximum value (2^`CNT_W`−1), `drop_cnt` holds.
- **Pop/load.** The FIFO is popped into the shift register when the FIFO is non-empty, `out_hold` is low, and either:
  - the FSM is in IDLE, or
  - the FSM is in SEND with nibble index == `NIBS`−1.
  - `NIBS` = `DATA_W`/`NIB_W`.
- **FSM states.**
  - **IDLE:** `out_valid` = 0 and `out_frame` = 0.
  - IDLE to SEND on a load; the nibble index resets to 0.
  - **SEND:** each cycle without `out_hold`, the index increments and the shift register shifts right by `NIB_W`.
  - SEND to SEND (back-to-back, no gap) on the last nibble when a load happens.
  - SEND to IDLE on the last nibble when the FIFO is empty.
- **Hold.** While `out_hold` = 1, `out_valid`, `out_frame`, `out_nibble`, the index and the state are all frozen. No pop occurs. FIFO writes and drops continue.
- **Output order.** `out_nibble` = `in_data[NIB_W-1:0]` first, and `in_data[DATA_W-1:DATA_W-NIB_W]` last.
- **Registered outputs.** All outputs are registered; there is no combinational path from input to output.
- **Reset mid-frame.** The frame in progress and the FIFO contents are discarded. The next accepted word starts a new frame with `out_frame` asserted.

## Timing

- **Latency.** `in_valid` at cycle 0 into an empty, idle block: the word is written at the end of cycle 0 and loaded at the end of cycle 1. `out_frame`, `out_valid` and nibble 0 appear in cycle 2.
- **Frame length.** One word occupies exactly `NIBS` consecutive `out_valid` cycles when `out_hold` stays low; each hold cycle adds one cycle.
- **Throughput.** One word per `NIBS` cycles. The sustained input rate above 1/`NIBS` overflows after the FIFO fills.
- **Simultaneous events.**
  - A pop and a push in the same cycle leave the count unchanged; they are legal when the FIFO is full.
  - When `rst` and `in_valid` occur together, reset wins and the word is not stored.
  - `out_hold` asserted on the cycle a load would occur suppresses the load.

## Structure

- **Shared package `fir_io_pkg`:** `DATA_W` and `NIB_W` defaults, the `NIBS` localparam, and the `ser_state_t` enum (IDLE, SEND).
- **Sub-module `fir_sync_fifo`:** a generic synchronous FIFO with push, pop, full, empty and count outputs, and the same `clk`/`rst` conventions.
- **Top level:** holds the FSM, shift register, nibble index and drop counter.
- **Chip wrapper integration:** the 32 output pads are replaced by 6 pads (`out_nibble[3:0]`, `out_valid`, `out_frame`) plus one input pad (`out_hold`). `drop_cnt` is observable through simulation only.

## Test plan

- **Single word.** Apply reset, then `in_valid` with 0x89ABCDEF at cycle 0. Required: cycles 2–9 show `out_nibble` F,E,D,C,B,A,9,8. `out_frame` is high in cycle 2 only. `out_valid` is high in cycles 2–9 and low in cycle 10.
- **Back-to-back.** Push 0x00000001 at cycle 0 and 0x76543210 at cycle 1. Required:
  - Nibbles 1,0,0,0,0,0,0,0 in cycles 2–9.
  - Nibbles 0,1,2,3,4,5,6,7 in cycles 10–17.
  - `out_frame` high in cycles 2 and 10 only.
  - `out_valid` continuous.
- **Overflow.** Use `FIFO_DEPTH` = 4 and `in_valid` in every cycle 0–9 with words w0..w9. Required:
  - `drop_cnt` = 4 (w5–w8 are dropped).
  - The transmitted word order is w0, w1, w2, w3, w4, w9.
  - The full-FIFO push at cycle 9 is accepted because of the simultaneous pop.
- **Hold.** Send 0x89ABCDEF and assert `out_hold` for 3 cycles starting at the cycle showing nibble index 3 (value C). Required: C is displayed for 4 cycles, the frame spans 11 cycles, and the nibble order is unchanged.
- **Reset mid-frame.** Assert `rst` during nibble 5 with 2 words queued. Required:
  - The next cycle shows all outputs 0 and `drop_cnt` = 0.
  - No queued word appears afterward.
  - A new push starts with `out_frame` 2 cycles later.
- **Drop counter saturation.** Use `CNT_W` = 2, hold `out_hold` high, and push 10 words. Required: `drop_cnt` = 3 and stays at 3.
